// File: rtl/alu_arb_pkg.sv
// Shared types for the LC-3 ALU arbiter: ALU op encoding, width and condition codes.
package alu_arb_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_NOT   = 2'b10,
    ALU_PASSA = 2'b11
  } alu_op_t;

  // {N, Z, P}
  typedef logic [2:0] nzp_t;

  function automatic nzp_t nzp_of(input logic [ALU_WIDTH-1:0] v);
    if (v[ALU_WIDTH-1]) return 3'b100;
    if (v == '0)        return 3'b010;
    return 3'b001;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for alu_arbiter. Rsp_NZP exists only when ALU_ARB_CC_EN is defined.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned WIDTH = ALU_WIDTH
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [N_REQ-1:0]            Req;
  logic [N_REQ-1:0][WIDTH-1:0] A_In;
  logic [N_REQ-1:0][WIDTH-1:0] B_In;
  logic [N_REQ-1:0][1:0]       K_In;
  logic                        Stall;
  logic [N_REQ-1:0]            Gnt;
  logic                        Rsp_Valid;
  logic [IdW-1:0]              Rsp_Id;
  logic [WIDTH-1:0]            Result;
`ifdef ALU_ARB_CC_EN
  nzp_t                        Rsp_NZP;

  modport master (
    output Req, A_In, B_In, K_In, Stall,
    input  Gnt, Rsp_Valid, Rsp_Id, Result, Rsp_NZP
  );
  modport slave (
    input  Req, A_In, B_In, K_In, Stall,
    output Gnt, Rsp_Valid, Rsp_Id, Result, Rsp_NZP
  );
`else
  modport master (
    output Req, A_In, B_In, K_In, Stall,
    input  Gnt, Rsp_Valid, Rsp_Id, Result
  );
  modport slave (
    input  Req, A_In, B_In, K_In, Stall,
    output Gnt, Rsp_Valid, Rsp_Id, Result
  );
`endif

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin select: first set req bit after 'last', wrapping modulo N_REQ.
module alu_arbiter_rr_picker #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  input  logic                     en,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic           found;
  logic [IdW-1:0] cand;

  // i runs to N_REQ so that 'last' itself is considered after all others.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IdW'((32'(last) + i) % N_REQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/lc3_alu.sv
// LC-3 ALU: ADD (mod 2^16), AND, NOT A, pass A. Purely combinational.
module lc3_alu
  import alu_arb_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  alu_op_t              k,
  output logic [ALU_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (k)
      ALU_ADD:   y = a + b;
      ALU_AND:   y = a & b;
      ALU_NOT:   y = ~a;
      ALU_PASSA: y = a;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one LC-3 ALU; capture stage then registered result.
// Define ALU_ARB_CC_EN to add the registered Rsp_NZP condition-code output.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input logic         Clk,
  input logic         Reset_n,
  alu_arbiter_if.slave bus
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic             pick_en;
  logic [N_REQ-1:0] gnt;
  logic [IdW-1:0]   gnt_idx;
  logic             gnt_any;

  logic [IdW-1:0]   last_q;
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  alu_op_t          s1_k_q;
  logic [IdW-1:0]   s1_id_q;

  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] result_q;
  logic             rsp_valid_q;
  logic [IdW-1:0]   rsp_id_q;

  // Grants are suppressed both under back-pressure and while held in reset.
  assign pick_en = Reset_n & ~bus.Stall;

  alu_arbiter_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req  (bus.Req),
    .last (last_q),
    .en   (pick_en),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign gnt_any = |gnt;
  assign bus.Gnt = gnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q     <= IdW'(N_REQ - 1);
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_k_q     <= ALU_ADD;
      s1_id_q    <= '0;
    end else if (!bus.Stall) begin
      s1_valid_q <= gnt_any;
      if (gnt_any) begin
        last_q  <= gnt_idx;
        s1_a_q  <= bus.A_In[gnt_idx];
        s1_b_q  <= bus.B_In[gnt_idx];
        s1_k_q  <= alu_op_t'(bus.K_In[gnt_idx]);
        s1_id_q <= gnt_idx;
      end
    end
  end

  lc3_alu u_alu (
    .a (s1_a_q),
    .b (s1_b_q),
    .k (s1_k_q),
    .y (alu_y)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else if (!bus.Stall) begin
      result_q    <= alu_y;
      rsp_valid_q <= s1_valid_q;
      rsp_id_q    <= s1_id_q;
    end
  end

  assign bus.Result    = result_q;
  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_Id    = rsp_id_q;

`ifdef ALU_ARB_CC_EN
  nzp_t nzp_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      nzp_q <= 3'b010;
    end else if (!bus.Stall) begin
      nzp_q <= nzp_of(alu_y);
    end
  end

  assign bus.Rsp_NZP = nzp_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single op, contention, stall, wrap-around ADD, mid-op reset.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  alu_arbiter_if #(.N_REQ(2), .WIDTH(16)) bus ();

  alu_arbiter #(
    .N_REQ (2),
    .WIDTH (16)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n   = 1'b0;
    bus.Stall = 1'b0;
    bus.Req   = 2'b11;
    bus.A_In[0] = 16'h7FFF; bus.B_In[0] = 16'h0001; bus.K_In[0] = 2'b00;
    bus.A_In[1] = 16'h5555; bus.B_In[1] = 16'h0000; bus.K_In[1] = 2'b11;

    // Reset held with requests pending
    cyc(); cyc();
    @(negedge Clk);
    chk("rst_gnt", 32'(bus.Gnt), 32'h0);
    chk("rst_valid", 32'(bus.Rsp_Valid), 32'h0);
    chk("rst_result", 32'(bus.Result), 32'h0);
    chk("rst_id", 32'(bus.Rsp_Id), 32'h0);
`ifdef ALU_ARB_CC_EN
    chk("rst_nzp", 32'(bus.Rsp_NZP), 32'h2);
`endif

    // Release: requester 0 wins first; single ADD 0x7FFF + 1
    cyc(); Reset_n = 1'b1;
    @(negedge Clk);
    chk("first_gnt", 32'(bus.Gnt), 32'h1);
    cyc(); bus.Req = 2'b00;
    @(negedge Clk);
    chk("single_gnt_idle", 32'(bus.Gnt), 32'h0);
    chk("single_t1_valid", 32'(bus.Rsp_Valid), 32'h0);
    cyc();
    @(negedge Clk);
    chk("single_valid", 32'(bus.Rsp_Valid), 32'h1);
    chk("single_result", 32'(bus.Result), 32'h8000);
    chk("single_id", 32'(bus.Rsp_Id), 32'h0);
`ifdef ALU_ARB_CC_EN
    chk("single_nzp", 32'(bus.Rsp_NZP), 32'h4);
`endif
    cyc();
    @(negedge Clk);
    chk("single_t3_valid", 32'(bus.Rsp_Valid), 32'h0);

    // Contention: Last=0, so grants go 10,01,10,01; results follow two cycles later
    bus.A_In[0] = 16'hF0F0; bus.B_In[0] = 16'h0FF0; bus.K_In[0] = 2'b01;
    bus.A_In[1] = 16'hF0F0; bus.B_In[1] = 16'hFFFF; bus.K_In[1] = 2'b01;
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus.Req = (k < 4) ? 2'b11 : 2'b00;
      @(negedge Clk);
      if (k < 4) chk("cont_gnt", 32'(bus.Gnt), (k % 2 == 0) ? 32'h2 : 32'h1);
      else       chk("cont_gnt_idle", 32'(bus.Gnt), 32'h0);
      if (k >= 2) begin
        chk("cont_valid", 32'(bus.Rsp_Valid), 32'h1);
        chk("cont_result", 32'(bus.Result), (k % 2 == 0) ? 32'hF0F0 : 32'h00F0);
        chk("cont_id", 32'(bus.Rsp_Id), (k % 2 == 0) ? 32'h1 : 32'h0);
      end
    end

    // Stall: NOT 0x1234 granted, then 3 stalled cycles with requester 1 asking
    cyc();
    bus.Req = 2'b01; bus.A_In[0] = 16'h1234; bus.K_In[0] = 2'b10;
    @(negedge Clk);
    chk("stall_grant", 32'(bus.Gnt), 32'h1);
    chk("stall_t0_valid", 32'(bus.Rsp_Valid), 32'h0);
    for (int s = 0; s < 3; s++) begin
      cyc();
      bus.Stall = 1'b1;
      bus.Req = 2'b10; bus.A_In[1] = 16'h8001; bus.K_In[1] = 2'b11;
      @(negedge Clk);
      chk("stall_gnt", 32'(bus.Gnt), 32'h0);
      chk("stall_valid", 32'(bus.Rsp_Valid), 32'h0);
      chk("stall_result", 32'(bus.Result), 32'h00F0);
    end
    // Stall falls while requester 1 is asking: grantable the same cycle
    cyc(); bus.Stall = 1'b0;
    @(negedge Clk);
    chk("unstall_gnt", 32'(bus.Gnt), 32'h2);
    chk("unstall_valid", 32'(bus.Rsp_Valid), 32'h0);
    chk("unstall_result", 32'(bus.Result), 32'h00F0);
    // Result is valid, then stalled for two cycles: must hold
    cyc(); bus.Req = 2'b00; bus.Stall = 1'b1;
    @(negedge Clk);
    chk("not_valid", 32'(bus.Rsp_Valid), 32'h1);
    chk("not_result", 32'(bus.Result), 32'hEDCB);
    chk("not_id", 32'(bus.Rsp_Id), 32'h0);
    cyc(); bus.Req = 2'b01;
    @(negedge Clk);
    chk("hold_gnt", 32'(bus.Gnt), 32'h0);
    chk("hold_valid", 32'(bus.Rsp_Valid), 32'h1);
    chk("hold_result", 32'(bus.Result), 32'hEDCB);
    cyc(); bus.Req = 2'b00; bus.Stall = 1'b0;
    @(negedge Clk);
    chk("hold2_result", 32'(bus.Result), 32'hEDCB);
    cyc();
    @(negedge Clk);
    chk("passa_valid", 32'(bus.Rsp_Valid), 32'h1);
    chk("passa_result", 32'(bus.Result), 32'h8001);
    chk("passa_id", 32'(bus.Rsp_Id), 32'h1);
`ifdef ALU_ARB_CC_EN
    chk("passa_nzp", 32'(bus.Rsp_NZP), 32'h4);
`endif
    cyc();
    @(negedge Clk);
    chk("passa_after_valid", 32'(bus.Rsp_Valid), 32'h0);

    // ADD wraps modulo 2^16
    cyc();
    bus.Req = 2'b01; bus.A_In[0] = 16'hFFFF; bus.B_In[0] = 16'h0001; bus.K_In[0] = 2'b00;
    @(negedge Clk);
    chk("wrap_gnt", 32'(bus.Gnt), 32'h1);
    cyc(); bus.Req = 2'b00;
    cyc();
    @(negedge Clk);
    chk("wrap_valid", 32'(bus.Rsp_Valid), 32'h1);
    chk("wrap_result", 32'(bus.Result), 32'h0000);
`ifdef ALU_ARB_CC_EN
    chk("wrap_nzp", 32'(bus.Rsp_NZP), 32'h2);
`endif

    // Reset right after a grant discards the op
    cyc();
    bus.Req = 2'b10; bus.A_In[1] = 16'h0002; bus.B_In[1] = 16'h0003; bus.K_In[1] = 2'b00;
    @(negedge Clk);
    chk("midrst_gnt", 32'(bus.Gnt), 32'h2);
    cyc(); bus.Req = 2'b00; Reset_n = 1'b0;
    @(negedge Clk);
    chk("midrst_valid0", 32'(bus.Rsp_Valid), 32'h0);
    cyc(); Reset_n = 1'b1;
    @(negedge Clk);
    chk("midrst_valid1", 32'(bus.Rsp_Valid), 32'h0);
    chk("midrst_result", 32'(bus.Result), 32'h0);
    cyc();
    @(negedge Clk);
    chk("midrst_valid2", 32'(bus.Rsp_Valid), 32'h0);
    cyc(); bus.Req = 2'b11;
    @(negedge Clk);
    chk("midrst_ptr_gnt", 32'(bus.Gnt), 32'h1);
    cyc(); bus.Req = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one LC-3 ALU between N_REQ requesters, e.g. the microsequencer datapath and a multi-cycle multiply/divide helper.
- Round-robin arbitration with a same-cycle grant.
- Two-stage pipeline: operand capture, then registered result. Throughput is one operation per cycle.
- Sits between the requesters and the existing ALU module. The ALU is instantiated, not re-implemented.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- WIDTH, 16, operand and result width; fixed by the LC-3 ALU.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Req  input  N_REQ  per-requester request. Held high, with operands stable, until the matching Gnt is seen.
- A_In  input  N_REQ x WIDTH  per-requester operand A.
- B_In  input  N_REQ x WIDTH  per-requester operand B.
- K_In  input  N_REQ x 2  per-requester ALU op: 00 ADD, 01 AND, 10 NOT A, 11 pass A.
- Stall  input  1  downstream back-pressure; freezes the whole pipeline.
- Gnt  output  N_REQ  one-hot grant, combinational, valid in the cycle the operands are accepted.
- Rsp_Valid  output  1  result valid.
- Rsp_Id  output  clog2(N_REQ)  index of the requester that owns Result.
- Result  output  WIDTH  registered ALU result.

Behaviour:
- Reset (async assert, sync-release timing irrelevant to the block):
  - Rsp_Valid=0, Result=0, Rsp_Id=0.
  - Stage-1 valid=0, stage-1 operands=0.
  - Round-robin pointer Last=N_REQ-1, so requester 0 wins first.
  - Gnt=0 while Reset_n=0.
- Arbitration (combinational):
  - If Stall=0 and Req!=0, grant exactly one requester: the first with Req set, searching Last+1, Last+2, ... modulo N_REQ.
  - If Stall=1, Gnt=0.
  - At most one Gnt bit per cycle.
- Stage 1 (edge ending grant cycle t):
  - If Stall=0: S1_Valid <= |Gnt; S1_A/S1_B/S1_K/S1_Id <= granted requester's inputs.
  - Last <= granted index only when a grant occurred.
  - With no grant, S1_Valid <= 0 and the operand registers may hold their old values.
- Stage 2 (edge ending cycle t+1), if Stall=0:
  - Result <= ALU(S1_A, S1_B, S1_K).
  - Rsp_Valid <= S1_Valid.
  - Rsp_Id <= S1_Id.
- Latency: Rsp_Valid and Result appear in cycle t+2 relative to the Gnt cycle t.
- Stall=1:
  - No grants issued.
  - All pipeline registers and Last hold their values.
  - Rsp_Valid and Result stay stable for the duration of the stall.
- Arithmetic: ADD is modulo 2^16; no carry or overflow output.
- Simultaneous events:
  - Req rising in the same cycle as Stall falling is grantable in that cycle.
  - A requester granted in cycle t may re-request in t+1 and compete normally.
- Req dropped before Gnt: legal; nothing is captured.
- Reset mid-operation: in-flight operations are discarded and no Rsp_Valid is produced for them.

Optional Feature:
- Macro: ALU_ARB_CC_EN.
- When defined:
  - Adds output Rsp_NZP [2:0], registered alongside Result at stage 2.
  - N = Result[15]; Z = (Result==0); P = otherwise. Exactly one bit is set when Rsp_Valid=1.
  - Reset value is 3'b010. Holds during Stall.
- When undefined: port absent; no condition-code logic.

Decomposition:
- Package alu_arb_pkg:
  - typedef alu_op_t, an enum over the K encodings: ALU_ADD, ALU_AND, ALU_NOT, ALU_PASSA.
  - Constant ALU_WIDTH=16.
  - typedef nzp_t.
- One natural sub-module, rr_picker: pure combinational round-robin select, taking Req, Last and enable and producing one-hot Gnt plus the index.
- The existing ALU module is instantiated in stage 2.

Test Plan:
- Reset: hold Reset_n=0 with Req=2'b11 -> Gnt=0, Rsp_Valid=0, Result=0. Release -> first Gnt=2'b01.
- Single op: Req[0], A=0x7FFF, B=0x0001, K=00 at cycle t -> Gnt=01 at t; Rsp_Valid=1, Result=0x8000, Rsp_Id=0 at t+2.
- Contention: Req=11 held for 4 cycles (both AND, A=0xF0F0, B=0x0FF0 / 0xFFFF) -> Gnt sequence 01,10,01,10. Results 0x00F0 (id 0) and 0xF0F0 (id 1) alternate, back-to-back with no bubble.
- Stall: issue NOT 0x1234, assert Stall at t+1 for 3 cycles -> no Gnt during the stall. Result 0xEDCB appears only 2 active cycles after the grant and stays stable while stalled.
- Mid-op reset: grant at t, pull Reset_n low at t+1 -> Rsp_Valid never asserts for that op.
- With ALU_ARB_CC_EN: ADD 0xFFFF+0x0001 -> Result=0x0000, Rsp_NZP=010. Pass-A 0x8001 -> Rsp_NZP=100.
